// File: rtl/riscv_decode_pkg.sv
// Shared decode types: opclass enum, opcode and OP-FP funct5 maps, decoded_t record.
// Pure declarations, no logic or latency of its own.
// Backpressure: not applicable.
package riscv_decode_pkg;

    typedef enum logic [4:0] {
        OC_BRANCH, OC_ALU_IMM, OC_ALU_REG, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC,
        OC_LOAD, OC_STORE, OC_SYSTEM,
        OC_FADD, OC_FSUB, OC_FMUL, OC_FDIV, OC_FSGNJ, OC_FMINMAX, OC_FSQRT,
        OC_FCMP, OC_FCVT_F2I, OC_FMV_F2I, OC_FCVT_I2F, OC_FMV_I2F,
        OC_FLW, OC_FSW, OC_FMADD, OC_FMSUB, OC_FNMSUB, OC_FNMADD,
        OC_ILLEGAL
    } opclass_e;

    // Major opcodes, inst[6:2]
    localparam logic [4:0] OPC_BRANCH = 5'h18;
    localparam logic [4:0] OPC_JAL    = 5'h1b;
    localparam logic [4:0] OPC_JALR   = 5'h19;
    localparam logic [4:0] OPC_LUI    = 5'h0d;
    localparam logic [4:0] OPC_AUIPC  = 5'h05;
    localparam logic [4:0] OPC_OP_IMM = 5'h04;
    localparam logic [4:0] OPC_OP     = 5'h0c;
    localparam logic [4:0] OPC_LOAD   = 5'h00;
    localparam logic [4:0] OPC_STORE  = 5'h08;
    localparam logic [4:0] OPC_SYSTEM = 5'h1c;
    localparam logic [4:0] OPC_FLW    = 5'h01;
    localparam logic [4:0] OPC_FSW    = 5'h09;
    localparam logic [4:0] OPC_FMADD  = 5'h10;
    localparam logic [4:0] OPC_FMSUB  = 5'h11;
    localparam logic [4:0] OPC_FNMSUB = 5'h12;
    localparam logic [4:0] OPC_FNMADD = 5'h13;
    localparam logic [4:0] OPC_OP_FP  = 5'h14;

    // OP-FP funct5, inst[31:27]
    localparam logic [4:0] F5_FADD     = 5'h00;
    localparam logic [4:0] F5_FSUB     = 5'h01;
    localparam logic [4:0] F5_FMUL     = 5'h02;
    localparam logic [4:0] F5_FDIV     = 5'h03;
    localparam logic [4:0] F5_FSGNJ    = 5'h04;
    localparam logic [4:0] F5_FMINMAX  = 5'h05;
    localparam logic [4:0] F5_FSQRT    = 5'h0b;
    localparam logic [4:0] F5_FCMP     = 5'h14;
    localparam logic [4:0] F5_FCVT_F2I = 5'h18;
    localparam logic [4:0] F5_FMV_F2I  = 5'h1c;
    localparam logic [4:0] F5_FCVT_I2F = 5'h1a;
    localparam logic [4:0] F5_FMV_I2F  = 5'h1e;

    typedef struct packed {
        opclass_e    opclass;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [2:0]  funct3_rm;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        uses_rs3;
        logic        writes_rd;
        logic        rd_is_fp;
        logic        rs1_is_fp;
        logic        rs2_is_fp;
        logic        illegal;
    } decoded_t;

    localparam int DEC_W = $bits(decoded_t);

    // FP classes occupy a contiguous range of the enum, FADD through FNMADD
    function automatic logic is_fp_class(input opclass_e oc);
        return (oc >= OC_FADD) && (oc <= OC_FNMADD);
    endfunction

endpackage

// File: rtl/riscv_decode_lane.sv
// Single-lane RV32IMF decoder: one instruction word to one decoded_t record.
// Purely combinational, zero latency.
// Backpressure: none, the enclosing stage owns the handshake.
module riscv_decode_lane
    import riscv_decode_pkg::*;
(
    input  logic [31:0] insn,
    output decoded_t    dec
);

    logic [4:0] opc;
    logic [4:0] f5;
    opclass_e   oc;
    logic       fp;
    logic       rd_fp;
    logic [2:0] f3;

    assign opc = insn[6:2];
    assign f5  = insn[31:27];
    assign f3  = insn[14:12];

    always_comb begin
        oc = OC_ILLEGAL;
        case (opc)
            OPC_BRANCH: oc = OC_BRANCH;
            OPC_JAL:    oc = OC_JAL;
            OPC_JALR:   oc = OC_JALR;
            OPC_LUI:    oc = OC_LUI;
            OPC_AUIPC:  oc = OC_AUIPC;
            OPC_OP_IMM: oc = OC_ALU_IMM;
            OPC_OP:     oc = OC_ALU_REG;
            OPC_LOAD:   oc = OC_LOAD;
            OPC_STORE:  oc = OC_STORE;
            OPC_SYSTEM: oc = OC_SYSTEM;
            OPC_FLW:    oc = OC_FLW;
            OPC_FSW:    oc = OC_FSW;
            OPC_FMADD:  oc = OC_FMADD;
            OPC_FMSUB:  oc = OC_FMSUB;
            OPC_FNMSUB: oc = OC_FNMSUB;
            OPC_FNMADD: oc = OC_FNMADD;
            OPC_OP_FP: begin
                case (f5)
                    F5_FADD:     oc = OC_FADD;
                    F5_FSUB:     oc = OC_FSUB;
                    F5_FMUL:     oc = OC_FMUL;
                    F5_FDIV:     oc = OC_FDIV;
                    F5_FSGNJ:    oc = OC_FSGNJ;
                    F5_FMINMAX:  oc = OC_FMINMAX;
                    F5_FSQRT:    oc = OC_FSQRT;
                    F5_FCMP:     oc = OC_FCMP;
                    F5_FCVT_F2I: oc = OC_FCVT_F2I;
                    F5_FMV_F2I:  oc = OC_FMV_F2I;
                    F5_FCVT_I2F: oc = OC_FCVT_I2F;
                    F5_FMV_I2F:  oc = OC_FMV_I2F;
                    default:     oc = OC_ILLEGAL;
                endcase
            end
            default: oc = OC_ILLEGAL;
        endcase
        // Only single precision is supported; fmt lives in [26:25] for OP-FP and the FMA group
        if (((opc == OPC_OP_FP) || (opc[4:2] == 3'b100)) && (insn[26:25] != 2'b00)) begin
            oc = OC_ILLEGAL;
        end
        if (insn[1:0] != 2'b11) begin
            oc = OC_ILLEGAL;
        end
    end

    assign fp    = is_fp_class(oc);
    assign rd_fp = fp && !(oc inside {OC_FCMP, OC_FCVT_F2I, OC_FMV_F2I});

    always_comb begin
        dec           = '0;
        dec.opclass   = oc;
        dec.rd        = insn[11:7];
        dec.rs1       = insn[19:15];
        dec.rs2       = insn[24:20];
        dec.rs3       = insn[31:27];
        dec.funct3_rm = f3;
        dec.funct7    = insn[31:25];
        dec.illegal   = (oc == OC_ILLEGAL);

        case (oc)
            OC_ALU_IMM, OC_LOAD, OC_JALR, OC_FLW, OC_SYSTEM:
                dec.imm = {{20{insn[31]}}, insn[31:20]};
            OC_STORE, OC_FSW:
                dec.imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OC_BRANCH:
                dec.imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            OC_LUI, OC_AUIPC:
                dec.imm = {insn[31:12], 12'b0};
            OC_JAL:
                dec.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:
                dec.imm = 32'd0;
        endcase

        // CSR register forms read rs1; immediate forms and ecall/ebreak do not
        dec.uses_rs1  = fp
                     || (oc inside {OC_BRANCH, OC_ALU_IMM, OC_ALU_REG, OC_JALR, OC_LOAD, OC_STORE})
                     || ((oc == OC_SYSTEM) && (f3 != 3'b000) && !f3[2]);
        dec.uses_rs2  = oc inside {OC_BRANCH, OC_ALU_REG, OC_STORE, OC_FSW,
                                   OC_FADD, OC_FSUB, OC_FMUL, OC_FDIV, OC_FSGNJ,
                                   OC_FMINMAX, OC_FCMP,
                                   OC_FMADD, OC_FMSUB, OC_FNMSUB, OC_FNMADD};
        dec.uses_rs3  = oc inside {OC_FMADD, OC_FMSUB, OC_FNMSUB, OC_FNMADD};
        dec.rd_is_fp  = rd_fp;
        dec.rs1_is_fp = fp && !(oc inside {OC_FLW, OC_FSW, OC_FCVT_I2F, OC_FMV_I2F});
        dec.rs2_is_fp = fp;
        dec.writes_rd = !(oc inside {OC_BRANCH, OC_STORE, OC_FSW, OC_ILLEGAL})
                     && ((insn[11:7] != 5'd0) || rd_fp);
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// Multi-lane registered decode stage with a main register and a one-entry skid.
// Latency: 1 cycle accept to out_valid; one bundle per cycle when out_ready is high.
// Backpressure: in_ready is registered and drops only while the skid entry is occupied.
module riscv_decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int INSN_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int PC_WIDTH   = 32
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*INSN_WIDTH-1:0] in_insn,
    input  logic [PC_WIDTH-1:0]         in_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic [LANES*DEC_W-1:0]      out_dec
);

    logic [LANES*DEC_W-1:0] dec_bus;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        riscv_decode_lane u_lane (
            .insn (in_insn[INSN_WIDTH*g +: INSN_WIDTH]),
            .dec  (dec_bus[DEC_W*g +: DEC_W])
        );
    end

    logic                   m_vld_q, m_vld_d;
    logic [PC_WIDTH-1:0]    m_pc_q,  m_pc_d;
    logic [LANES*DEC_W-1:0] m_dec_q, m_dec_d;
    logic                   s_vld_q, s_vld_d;
    logic [PC_WIDTH-1:0]    s_pc_q,  s_pc_d;
    logic [LANES*DEC_W-1:0] s_dec_q, s_dec_d;
    logic                   in_rdy_q, in_rdy_d;

    logic accept;
    logic m_free;

    assign accept = in_valid && in_rdy_q;
    assign m_free = !m_vld_q || out_ready;

    always_comb begin
        m_vld_d = m_vld_q;
        m_pc_d  = m_pc_q;
        m_dec_d = m_dec_q;
        s_vld_d = s_vld_q;
        s_pc_d  = s_pc_q;
        s_dec_d = s_dec_q;

        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (m_free) begin
            // A full skid implies in_ready was low, so no accept competes with the refill
            if (s_vld_q) begin
                m_vld_d = 1'b1;
                m_pc_d  = s_pc_q;
                m_dec_d = s_dec_q;
                s_vld_d = 1'b0;
            end else if (accept) begin
                m_vld_d = 1'b1;
                m_pc_d  = in_pc;
                m_dec_d = dec_bus;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (accept) begin
            s_vld_d = 1'b1;
            s_pc_d  = in_pc;
            s_dec_d = dec_bus;
        end

        in_rdy_d = !s_vld_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_vld_q  <= 1'b0;
            m_pc_q   <= '0;
            m_dec_q  <= '0;
            s_vld_q  <= 1'b0;
            s_pc_q   <= '0;
            s_dec_q  <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            m_vld_q  <= m_vld_d;
            m_pc_q   <= m_pc_d;
            m_dec_q  <= m_dec_d;
            s_vld_q  <= s_vld_d;
            s_pc_q   <= s_pc_d;
            s_dec_q  <= s_dec_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = m_vld_q;
    assign out_pc    = m_pc_q;
    assign out_dec   = m_dec_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage with four lanes: decode vectors, stall/skid ordering,
// flush and asynchronous reset.
module tb_riscv_decode_stage;
    import riscv_decode_pkg::*;

    localparam int L = 4;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [L*32-1:0]    in_insn;
    logic [31:0]        in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [L*DEC_W-1:0] out_dec;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_decode_stage #(.INSN_WIDTH(32), .LANES(L), .PC_WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_dec   (out_dec)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic decoded_t lane_of(input int i);
        return out_dec[i*DEC_W +: DEC_W];
    endfunction

    // Lane i of bundle k: addi x(i+1), x0, 4*k+i
    function automatic logic [L*32-1:0] mk_bundle(input int k);
        logic [L*32-1:0] b;
        logic [11:0]     imm;
        logic [4:0]      rd;
        b = '0;
        for (int i = 0; i < L; i++) begin
            imm = 12'(k*4 + i);
            rd  = 5'(i + 1);
            b[32*i +: 32] = {imm, 5'd0, 3'b000, rd, 7'h13};
        end
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        decoded_t d;
        int       exp_q[$];
        int       k;
        int       popped;
        int       e;
        logic     saw_low;
        logic     late_vld;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_dec", 64'(out_dec[63:0]), 64'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        reset_n = 1'b1;

        // Decode vectors: addi, beq, fadd.s, all-zero word
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_insn   = {32'h0000_0000, 32'h0020_81D3, 32'hFE00_0EE3, 32'hFFF1_0093};
        #1 chk("lat_before", out_valid, 1'b0);
        @(negedge clock);
        in_pc   = 32'h200;
        in_insn = {32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0200_0053};
        #1;
        chk("lat_after", out_valid, 1'b1);
        chk("a_pc", out_pc, 32'h100);
        d = lane_of(0);
        chk("addi_oc", d.opclass, OC_ALU_IMM);
        chk("addi_rd", d.rd, 5'd1);
        chk("addi_rs1", d.rs1, 5'd2);
        chk("addi_imm", d.imm, 32'hFFFF_FFFF);
        chk("addi_wr", d.writes_rd, 1'b1);
        chk("addi_rs1fp", d.rs1_is_fp, 1'b0);
        d = lane_of(1);
        chk("beq_oc", d.opclass, OC_BRANCH);
        chk("beq_imm", d.imm, 32'hFFFF_FFFC);
        chk("beq_wr", d.writes_rd, 1'b0);
        chk("beq_rs2", d.uses_rs2, 1'b1);
        d = lane_of(2);
        chk("fadd_oc", d.opclass, OC_FADD);
        chk("fadd_rd", d.rd, 5'd3);
        chk("fadd_rdfp", d.rd_is_fp, 1'b1);
        chk("fadd_rs1fp", d.rs1_is_fp, 1'b1);
        chk("fadd_rs2fp", d.rs2_is_fp, 1'b1);
        chk("fadd_rs3", d.uses_rs3, 1'b0);
        chk("fadd_imm", d.imm, 32'd0);
        d = lane_of(3);
        chk("zero_oc", d.opclass, OC_ILLEGAL);
        chk("zero_ill", d.illegal, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("b_pc", out_pc, 32'h200);
        d = lane_of(0);
        chk("fmt1_oc", d.opclass, OC_ILLEGAL);
        chk("fmt1_ill", d.illegal, 1'b1);
        chk("fmt1_f7", d.funct7, 7'h01);
        d = lane_of(1);
        chk("nop_ill", d.illegal, 1'b0);
        chk("nop_wr", d.writes_rd, 1'b0);

        // Drain, then stream 8 bundles with a 3-cycle downstream stall
        @(negedge clock);
        k       = 0;
        popped  = 0;
        saw_low = 1'b0;
        for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
            @(negedge clock);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (k < 8);
            in_pc     = 32'h100 + 32'(k) * 32'd16;
            in_insn   = mk_bundle(k);
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", out_pc, 32'h100 + 32'(e) * 32'd16);
                    d = lane_of(0);
                    chk("stream_l0_imm", d.imm, 32'(e * 4));
                    d = lane_of(3);
                    chk("stream_l3_imm", d.imm, 32'(e * 4 + 3));
                    chk("stream_l3_rd", d.rd, 5'd4);
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(k);
                k++;
            end
        end
        chk("stream_count", popped, 8);
        chk("stream_rdy_drop", saw_low, 1'b1);
        in_valid = 1'b0;

        // Flush with main and skid full and input still offered
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'hA00;
        in_insn   = mk_bundle(20);
        repeat (2) @(negedge clock);
        #1;
        chk("pre_flush_rdy", in_ready, 1'b0);
        chk("pre_flush_vld", out_valid, 1'b1);
        flush = 1'b1;
        @(negedge clock);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_vld", out_valid, 1'b0);
        chk("flush_rdy", in_ready, 1'b1);
        late_vld = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (out_valid) late_vld = 1'b1;
        end
        chk("flush_no_ghost", late_vld, 1'b0);

        // Asynchronous reset mid-stream
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'hC00;
        in_insn   = mk_bundle(5);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("prerst_vld", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 1'b0);
        chk("arst_rdy", in_ready, 1'b1);
        @(negedge clock);
        reset_n   = 1'b1;
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        in_insn   = {32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'hFFF1_0093};
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("post_rst_vld", out_valid, 1'b1);
        chk("post_rst_pc", out_pc, 32'h300);
        d = lane_of(0);
        chk("post_rst_oc", d.opclass, OC_ALU_IMM);
        chk("post_rst_imm", d.imm, 32'hFFFF_FFFF);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
